// File: rtl/m_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : m_fb_writer
//  Description : Pixel write queue between a renderer and a framebuffer port,
//                with bounds filtering, drop counting and per-frame flush.
//  Revision    : 1.0
// ============================================================================
module m_fb_writer #(
    parameter int DEPTH = 4,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot_valid,
    output logic        plot_ready,
    input  logic [7:0]  plot_x,
    input  logic [6:0]  plot_y,
    input  logic [11:0] plot_color,
    input  logic        frame_done,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_data,
    output logic        mem_wren,
    input  logic        mem_grant,
    output logic [7:0]  dropped_count,
    output logic        busy,
    output logic        flushed
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_ENT_W = 27;

    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [8:0]         c_FB_W_X    = 9'(FB_W);
    localparam logic [7:0]         c_FB_H_Y    = 8'(FB_H);
    localparam logic [14:0]        c_FB_W_ADDR = 15'(FB_W);

    localparam logic [0:0] c_ST_ACCEPT = 1'b0;
    localparam logic [0:0] c_ST_FLUSH  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               w_flush_done;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [7:0]         r_dropped;
    logic               r_flushed;
    logic [c_ENT_W-1:0] r_queue [DEPTH];

    logic               w_accept;
    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic [14:0]        w_addr;

    assign w_nonempty = (r_count != '0);
    assign plot_ready = (r_state == c_ST_ACCEPT) && (r_count < c_DEPTH);
    assign w_accept   = plot_valid && plot_ready;
    assign w_in_range = ({1'b0, plot_x} < c_FB_W_X) && ({1'b0, plot_y} < c_FB_H_Y);
    assign w_push     = w_accept && w_in_range;

    // Full 15-bit arithmetic so the largest in-range address cannot wrap.
    assign w_addr = ({8'd0, plot_y} * c_FB_W_ADDR) + {7'd0, plot_x};

    assign mem_wren = w_nonempty && mem_grant;
    assign w_pop    = mem_wren;
    assign {mem_addr, mem_data} = r_queue[r_head];

    assign dropped_count = r_dropped;
    assign busy          = w_nonempty || (r_state == c_ST_FLUSH);
    assign flushed       = r_flushed;

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_queue[r_tail] <= {w_addr, plot_color};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == c_PTR_LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_PTR_LAST) ? '0 : r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dropped <= '0;
        end else if (w_accept && !w_in_range && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_ST_ACCEPT;
            r_flushed <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_flushed <= w_flush_done;
        end
    end

    // A frame_done seen while already flushing is ignored.
    always_comb begin
        w_state_next = r_state;
        w_flush_done = 1'b0;
        case (r_state)
            c_ST_ACCEPT: begin
                if (frame_done) begin
                    w_state_next = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                if (!w_nonempty) begin
                    w_state_next = c_ST_ACCEPT;
                    w_flush_done = 1'b1;
                end
            end
            default: begin
                w_state_next = c_ST_ACCEPT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_m_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_fb_writer
//  Description : Scoreboard bench for m_fb_writer with directed pixel vectors.
//  Revision    : 1.0
// ============================================================================
module tb_m_fb_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        plot_valid = 1'b0;
    logic        plot_ready;
    logic [7:0]  plot_x = '0;
    logic [6:0]  plot_y = '0;
    logic [11:0] plot_color = '0;
    logic        frame_done = 1'b0;
    logic [14:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_wren;
    logic        mem_grant = 1'b0;
    logic [7:0]  dropped_count;
    logic        busy;
    logic        flushed;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    int n_flush  = 0;
    logic [26:0] sb[$];

    m_fb_writer #(.DEPTH(4), .FB_W(160), .FB_H(120)) dut (
        .clock(clock), .reset(reset),
        .plot_valid(plot_valid), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
        .frame_done(frame_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_grant(mem_grant),
        .dropped_count(dropped_count), .busy(busy), .flushed(flushed)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every framebuffer write is popped against the scoreboard.
    always @(negedge clock) begin
        if (flushed === 1'b1) n_flush++;
        if (!reset && mem_wren === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", {17'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [26:0] e;
                e = sb.pop_front();
                check("write_addr", {17'd0, mem_addr}, {17'd0, e[26:12]});
                check("write_data", {20'd0, mem_data}, {20'd0, e[11:0]});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [11:0] c,
                        input bit exp_acc, input bit exp_wr, input logic [14:0] ea);
        plot_valid = 1'b1;
        plot_x = x; plot_y = y; plot_color = c;
        @(negedge clock);
        check("plot_ready", {31'd0, plot_ready}, {31'd0, exp_acc});
        if (exp_wr) sb.push_back({ea, c});
        @(posedge clock);
        #1;
        plot_valid = 1'b0;
    endtask

    initial begin
        int w0, f0;
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0;
        cyc(2);
        reset = 1'b0;
        @(negedge clock);
        check("rst_wren", {31'd0, mem_wren}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ready", {31'd0, plot_ready}, 1);
        check("rst_dropped", {24'd0, dropped_count}, 0);
        check("rst_flushed", {31'd0, flushed}, 0);
        cyc(1);

        // Single write
        mem_grant = 1'b1;
        w0 = n_writes;
        plot(8'd3, 7'd2, 12'hFF3, 1'b1, 1'b1, 15'd323);
        cyc(4);
        check("single_write_count", n_writes - w0, 1);

        // Backpressure: four fit, fifth is refused
        mem_grant = 1'b0;
        w0 = n_writes;
        plot(8'd0,  7'd0, 12'h111, 1'b1, 1'b1, 15'd0);
        plot(8'd1,  7'd0, 12'h222, 1'b1, 1'b1, 15'd1);
        plot(8'd0,  7'd1, 12'h333, 1'b1, 1'b1, 15'd160);
        plot(8'd20, 7'd3, 12'h444, 1'b1, 1'b1, 15'd500);
        plot(8'd5,  7'd5, 12'h555, 1'b0, 1'b0, 15'd0);
        @(negedge clock);
        check("bp_ready_full", {31'd0, plot_ready}, 0);
        check("bp_busy", {31'd0, busy}, 1);
        check("bp_no_write", n_writes - w0, 0);
        cyc(1);
        mem_grant = 1'b1;
        cyc(6);
        check("bp_write_count", n_writes - w0, 4);
        @(negedge clock);
        check("bp_ready_again", {31'd0, plot_ready}, 1);
        cyc(1);

        // Bounds
        w0 = n_writes;
        plot(8'd160, 7'd0,   12'hABC, 1'b1, 1'b0, 15'd0);
        plot(8'd0,   7'd120, 12'hABC, 1'b1, 1'b0, 15'd0);
        plot(8'd159, 7'd119, 12'h0A5, 1'b1, 1'b1, 15'd19199);
        cyc(3);
        check("bounds_dropped", {24'd0, dropped_count}, 2);
        check("bounds_writes", n_writes - w0, 1);

        // Flush with stalled memory
        mem_grant = 1'b0;
        w0 = n_writes;
        f0 = n_flush;
        plot(8'd1,  7'd0, 12'h00F, 1'b1, 1'b1, 15'd1);
        plot(8'd0,  7'd1, 12'h0F0, 1'b1, 1'b1, 15'd160);
        plot(8'd10, 7'd5, 12'hF00, 1'b1, 1'b1, 15'd810);
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        @(negedge clock);
        check("flush_ready", {31'd0, plot_ready}, 0);
        check("flush_busy", {31'd0, busy}, 1);
        cyc(1);
        mem_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("flush_ready_hold", {31'd0, plot_ready}, 0);
            cyc(1);
        end
        mem_grant = 1'b0;
        cyc(4);
        check("flush_writes", n_writes - w0, 3);
        check("flush_pulses", n_flush - f0, 1);
        @(negedge clock);
        check("flush_ready_after", {31'd0, plot_ready}, 1);
        check("flush_busy_after", {31'd0, busy}, 0);
        cyc(1);

        // Empty-queue frame_done still produces one flushed pulse
        f0 = n_flush;
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        cyc(4);
        check("empty_flush_pulses", n_flush - f0, 1);

        // Drop counter saturation
        mem_grant = 1'b1;
        for (int i = 0; i < 300; i++) begin
            plot(8'd200, 7'(i % 100), 12'h777, 1'b1, 1'b0, 15'd0);
        end
        cyc(1);
        check("sat_dropped", {24'd0, dropped_count}, 255);

        // Reset mid-flush discards the queue
        mem_grant = 1'b0;
        w0 = n_writes;
        f0 = n_flush;
        plot(8'd7, 7'd7, 12'h123, 1'b1, 1'b0, 15'd0);
        plot(8'd8, 7'd8, 12'h456, 1'b1, 1'b0, 15'd0);
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        mem_grant = 1'b1;
        cyc(5);
        check("rst_mid_writes", n_writes - w0, 0);
        check("rst_mid_flushed", n_flush - f0, 0);
        @(negedge clock);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_ready", {31'd0, plot_ready}, 1);
        check("rst_mid_dropped", {24'd0, dropped_count}, 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_fb_writer.md
M_FB_WRITER -- requirements
Module: m_fb_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-queue entries (power of two).
REQ-002 SHALL have parameter FB_W, default 160, meaning framebuffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 120, meaning framebuffer height in pixels.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port plot_valid  input  1  renderer presents a pixel write this cycle.
REQ-007 SHALL have port plot_ready  output  1  block accepts the presented pixel this cycle.
REQ-008 SHALL have port plot_x  input  8  pixel column.
REQ-009 SHALL have port plot_y  input  7  pixel row.
REQ-010 SHALL have port plot_color  input  12  pixel colour, 4-bit R,G,B.
REQ-011 SHALL have port frame_done  input  1  one-cycle pulse, renderer finished a frame.
REQ-012 SHALL have port mem_addr  output  15  framebuffer write address.
REQ-013 SHALL have port mem_data  output  12  framebuffer write data.
REQ-014 SHALL have port mem_wren  output  1  framebuffer write strobe.
REQ-015 SHALL have port mem_grant  input  1  framebuffer write port available this cycle.
REQ-016 SHALL have port dropped_count  output  8  out-of-range pixels discarded since reset.
REQ-017 SHALL have port busy  output  1  queue non-empty or flush in progress.
REQ-018 SHALL have port flushed  output  1  one-cycle pulse, frame fully written to memory.

Function
REQ-019 SHALL accept a pixel (handshake) on any rising edge where plot_valid and plot_ready are both 1.
REQ-020 SHALL drive plot_ready = 1 iff state is ACCEPT and queue count < DEPTH; no same-cycle pop bypass.
REQ-021 SHALL, on accept with plot_x < FB_W and plot_y < FB_H, enqueue {plot_y*FB_W + plot_x, plot_color}, address computed at full 15-bit width without truncation.
REQ-022 SHALL, on accept with plot_x >= FB_W or plot_y >= FB_H, not enqueue and increment dropped_count, saturating at 255.
REQ-023 SHALL drive mem_addr/mem_data combinationally from queue head, and mem_wren = (queue non-empty) AND mem_grant.
REQ-024 SHALL pop the queue head on every cycle mem_wren = 1; writes leave memory in enqueue order.
REQ-025 SHALL keep count unchanged on simultaneous enqueue and pop; head/tail pointers wrap modulo DEPTH.
REQ-026 SHALL implement states ACCEPT and FLUSH; ACCEPT -> FLUSH on frame_done = 1; FLUSH -> ACCEPT when queue empty.
REQ-027 SHALL, if frame_done coincides with an accept, enqueue that pixel as part of the flushing frame.
REQ-028 SHALL hold plot_ready = 0 for every cycle in FLUSH.
REQ-029 SHALL pulse flushed = 1 for exactly one cycle, on the FLUSH -> ACCEPT transition edge.
REQ-030 SHALL, with frame_done in FLUSH, ignore it; frame_done in ACCEPT with an empty queue SHALL still pass through FLUSH for one cycle, then pulse flushed.
REQ-031 SHALL drive busy = (queue non-empty) OR (state = FLUSH).
REQ-032 SHALL hold queue contents while mem_grant = 0; no data loss under any stall length.

Reset
REQ-033 SHALL, while reset = 1 at a clock edge, set state = ACCEPT, count = 0, pointers = 0, dropped_count = 0, flushed = 0.
REQ-034 SHALL give mem_wren = 0, busy = 0 and plot_ready = 1 in the cycle after reset; mem_addr/mem_data are don't-care while mem_wren = 0.
REQ-035 SHALL discard all queued pixels and abort any flush without pulsing flushed when reset asserts mid-operation.

Verification
REQ-036 Single write: mem_grant = 1, plot (x=3,y=2,color=FF3) -> next cycle mem_wren = 1, mem_addr = 323, mem_data = FF3, one cycle only.
REQ-037 Backpressure: mem_grant = 0, 5 valid plots offered -> 4 accepted, plot_ready = 0 after 4th; mem_grant = 1 -> 4 writes in order, plot_ready = 1 again.
REQ-038 Bounds: plots (160,0), (0,120), (159,119) -> dropped_count = 2, single write at mem_addr = 19199.
REQ-039 Flush: 3 queued, mem_grant = 0, frame_done pulse -> plot_ready = 0, busy = 1; grant 3 cycles -> 3 writes, one flushed pulse, plot_ready = 1.
REQ-040 Saturation and reset: 300 out-of-range plots -> dropped_count = 255; reset mid-flush with 2 queued -> no writes, no flushed pulse, count = 0.
